sound_rom_player: RTL

//  Sequences playback of one on-chip sound-sample ROM (16-bit single-port altsyncram, 1-cycle read latency).
//  On a trigger, walks addresses 0..NUM_SAMPLES-1 and fetches each word with ROM clken.

---
 rtl/sound_pkg.sv | 17 +
 rtl/sound_rom_player_if.sv | 26 ++
 rtl/sound_rom_player.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: shared definitions for the sound ROM player.
//   DefAddrW / DefDataW / DefNumSamples : default ROM geometry
//   state_e                             : playback FSM states
package sound_pkg;

  localparam int unsigned DefAddrW      = 14;
  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefNumSamples = 13000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCapture,
    StPresent
  } state_e;

endpackage

// File: rtl/sound_rom_player_if.sv
// sound_rom_player_if: valid/ready sample stream from the player to the mixer/codec FIFO.
//   sample_data  : attenuated signed sample (DATA_W bits)
//   sample_valid : sample_data is offered
//   sample_ready : sink accepts; a transfer happens when valid & ready
// Modports: master (player side), slave (sink side).
interface sound_rom_player_if #(
  parameter int unsigned DATA_W = sound_pkg::DefDataW
);

  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/sound_rom_player.sv
// sound_rom_player: plays one sound-sample ROM (1-cycle read latency) into a valid/ready stream.
// A trigger walks addresses 0..NUM_SAMPLES-1, one ROM fetch per sample; each word is
// arithmetically shifted right by vol_shift and offered on smp until accepted.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   trigger / stop    : 1-cycle start(restart) / abort pulses; stop wins when both are high
//   loop              : continuous replay (only with SOUND_LOOP_EN)
//   vol_shift         : attenuation shift 0..7
//   rom_address/clken : ROM read port, rom_readdata valid the cycle after a fetch
//   smp               : sample stream (master modport)
//   busy / done       : not idle / 1-cycle pulse after the last sample of a pass transfers
// Optional feature macro: SOUND_LOOP_EN (undefined: loop is ignored, playback is one-shot).
module sound_rom_player
  import sound_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned NUM_SAMPLES = DefNumSamples
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              stop,
  input  logic              loop,
  input  logic [2:0]        vol_shift,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  sound_rom_player_if.master smp,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_SAMPLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              restart_q, restart_d;  // trigger seen while a sample is still offered
  logic              done_q, done_d;
  logic              loop_on;

  logic signed [DATA_W-1:0] rd_s;
  assign rd_s = rom_readdata;

`ifdef SOUND_LOOP_EN
  assign loop_on = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_on     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      sample_q  <= '0;
      restart_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sample_q  <= sample_d;
      restart_q <= restart_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sample_d  = sample_q;
    restart_d = restart_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger && !stop) begin
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch, StCapture: begin
        if (stop) begin
          state_d = StIdle;
        end else if (trigger) begin
          // Restart drops the in-flight word
          addr_d  = '0;
          state_d = StFetch;
        end else if (state_q == StFetch) begin
          state_d = StCapture;
        end else begin
          sample_d = DATA_W'(rd_s >>> vol_shift);
          state_d  = StPresent;
        end
      end
      StPresent: begin
        if (stop) begin
          state_d   = StIdle;
          restart_d = 1'b0;
        end else begin
          if (trigger) restart_d = 1'b1;
          if (smp.sample_ready) begin
            state_d   = StFetch;
            restart_d = 1'b0;
            if (restart_q || trigger) begin
              addr_d = '0;
            end else if (addr_q == LastAddr) begin
              done_d = 1'b1;
              if (loop_on) addr_d = '0;
              else         state_d = StIdle;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    rom_address      = addr_q;
    rom_clken        = (state_q == StFetch);
    smp.sample_data  = sample_q;
    smp.sample_valid = (state_q == StPresent);
    busy             = (state_q != StIdle);
    done             = done_q;
  end

endmodule
